// File: rtl/nms_pkg.sv
// Shared types for the NMS pair scheduler: box field layout, in-flight pair tag, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nms_pkg;

  localparam int BOX_W = 64;
  localparam int X_MSB = 63;
  localparam int X_LSB = 52;
  localparam int Y_MSB = 51;
  localparam int Y_LSB = 40;
  localparam int W_MSB = 39;
  localparam int W_LSB = 28;
  localparam int H_MSB = 27;
  localparam int H_LSB = 16;
  localparam int S_MSB = 15;
  localparam int S_LSB = 0;

  localparam int CALU_LAT_DFLT = 12;

  // Tag index width covers the default 64-entry buffer; MAX_BOXES must not exceed 2**TAG_IDX_W.
  localparam int TAG_IDX_W = 6;

  typedef struct packed {
    logic                 v;
    logic [TAG_IDX_W-1:0] i;
    logic [TAG_IDX_W-1:0] j;
  } pair_tag_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROW,
    ST_ISSUE,
    ST_DRAIN,
    ST_DRAIN_FINAL,
    ST_EMIT,
    ST_DONE
  } nms_state_t;

endpackage

// File: rtl/nms_tag_pipe.sv
// Delay line of pair tags that tracks which (i, j) pair each CALU result belongs to.
// Latency: DEPTH cycles from tag_in to tag_out.
// Backpressure: none; shifts every cycle, synchronous active-low clear drops all tags.
module nms_tag_pipe
  import nms_pkg::*;
#(
  parameter int DEPTH = CALU_LAT_DFLT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  pair_tag_t tag_in,
  output pair_tag_t tag_out,
  output logic      any_vld
);

  pair_tag_t stage [DEPTH];

  // Advance every tag one stage per cycle; reset invalidates all in-flight pairs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

  // Any pair still awaiting its CALU result
  always_comb begin
    any_vld = 1'b0;
    for (int k = 0; k < DEPTH; k++) any_vld = any_vld | stage[k].v;
  end

endmodule

// File: rtl/nms_pair_scheduler.sv
// NMS frame sequencer: buffers boxes, issues every (i, j>i) pair to the CALU, applies suppression, streams survivors.
// Latency: one pair per cycle; results return CALU_LAT cycles after the pair is presented; each row is drained before the next.
// Backpressure: in_ready only in LOAD; EMIT holds out_data until out_ready. Option macro: NMS_SKIP_SUPPRESSED_EN.
module nms_pair_scheduler
  import nms_pkg::*;
#(
  parameter int MAX_BOXES = 64,
  parameter int IDX_W     = $clog2(MAX_BOXES),
  parameter int CALU_LAT  = CALU_LAT_DFLT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [IDX_W:0] num_boxes,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [63:0]    in_data,
  output logic [63:0]    calu_box1,
  output logic [63:0]    calu_box2,
  input  logic           calu_overlap,
  input  logic           calu_iou_pass,
  input  logic           calu_s_gt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [63:0]    out_data,
  output logic           out_last,
  output logic           busy,
  output logic           done,
  output logic [15:0]    pair_count
);

  localparam int            CW      = IDX_W + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BOXES);

  nms_state_t           state, state_nxt;
  logic [BOX_W-1:0]     box_buf [MAX_BOXES];
  logic [MAX_BOXES-1:0] keep;
  logic [CW-1:0]        n_boxes, n_last, wr_idx, i_idx, j_idx, k_idx;
  logic                 keep_i, keep_k, later_kept, skip_j;
  logic                 load_acc, issue_en, emit_adv, res_hit, pipe_vld;
  pair_tag_t            cur_tag, res_tag;

  assign n_last   = n_boxes - CW'(1);
  assign keep_i   = keep[i_idx[IDX_W-1:0]];
  assign keep_k   = keep[k_idx[IDX_W-1:0]];
  assign load_acc = (state == ST_LOAD) && in_valid;
  assign issue_en = (state == ST_ISSUE) && !skip_j;
  assign emit_adv = (state == ST_EMIT) && (!keep_k || out_ready);
  // A result only counts while both boxes of its pair are still alive
  assign res_hit  = res_tag.v && keep[res_tag.i] && keep[res_tag.j] && calu_overlap && calu_iou_pass;

`ifdef NMS_SKIP_SUPPRESSED_EN
  logic keep_j;
  assign keep_j = keep[j_idx[IDX_W-1:0]];
  assign skip_j = !keep_j;
`else
  assign skip_j = 1'b0;
`endif

  // Tag pipe is fed from the registered tag, so its output lines up with results CALU_LAT cycles after presentation
  nms_tag_pipe #(.DEPTH(CALU_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (cur_tag),
    .tag_out (res_tag),
    .any_vld (pipe_vld)
  );

  // Is any box after the current emit index still kept (drives out_last)
  always_comb begin
    later_kept = 1'b0;
    for (int m = 0; m < MAX_BOXES; m++)
      if ((CW'(m) > k_idx) && (CW'(m) < n_boxes) && keep[m]) later_kept = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/stream outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (num_boxes == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx == n_last)) state_nxt = ST_ROW;
      end
      ST_ROW: begin
        if (i_idx >= n_last) state_nxt = ST_DRAIN_FINAL;
        else if (keep_i)     state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (j_idx == n_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipe_vld && !cur_tag.v) state_nxt = ST_ROW;
      end
      ST_DRAIN_FINAL: begin
        if (!pipe_vld && !cur_tag.v) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (keep_k) begin
          out_valid = 1'b1;
          out_data  = box_buf[k_idx[IDX_W-1:0]];
          out_last  = !later_kept;
        end
        if (emit_adv && (k_idx == n_last)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame size, load pointer and the row/column/emit scan indices
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_boxes <= '0;
      wr_idx  <= '0;
      i_idx   <= '0;
      j_idx   <= '0;
      k_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          n_boxes <= (num_boxes > MAX_CNT) ? MAX_CNT : num_boxes;
          wr_idx  <= '0;
          i_idx   <= '0;
        end
        ST_LOAD: if (load_acc) wr_idx <= wr_idx + CW'(1);
        ST_ROW: if (i_idx < n_last) begin
          if (keep_i) j_idx <= i_idx + CW'(1);
          else        i_idx <= i_idx + CW'(1);
        end
        ST_ISSUE:       j_idx <= j_idx + CW'(1);
        ST_DRAIN:       if (state_nxt == ST_ROW) i_idx <= i_idx + CW'(1);
        ST_DRAIN_FINAL: k_idx <= '0;
        ST_EMIT:        if (emit_adv) k_idx <= k_idx + CW'(1);
        default: ;
      endcase
    end
  end

  // Box storage; contents are only meaningful after LOAD, so no reset
  always_ff @(posedge clk) begin
    if (load_acc) box_buf[wr_idx[IDX_W-1:0]] <= in_data;
  end

  // Pair issue: register CALU operands and the matching tag, count pairs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      calu_box1  <= '0;
      calu_box2  <= '0;
      cur_tag    <= '0;
      pair_count <= '0;
    end else begin
      cur_tag.v <= 1'b0;
      if (issue_en) begin
        calu_box1 <= box_buf[i_idx[IDX_W-1:0]];
        calu_box2 <= box_buf[j_idx[IDX_W-1:0]];
        cur_tag.v <= 1'b1;
        cur_tag.i <= TAG_IDX_W'(i_idx);
        cur_tag.j <= TAG_IDX_W'(j_idx);
        if (pair_count != 16'hFFFF) pair_count <= pair_count + 16'd1;
      end else if ((state == ST_IDLE) && start) begin
        pair_count <= '0;
      end
    end
  end

  // Keep mask: lower-scoring box of an overlapping pair is cleared; whole mask re-armed at frame end
  always_ff @(posedge clk) begin
    if (!rst_n || (state == ST_DONE)) begin
      keep <= '1;
    end else begin
      if (load_acc) keep[wr_idx[IDX_W-1:0]] <= 1'b1;
      if (res_hit) begin
        if (calu_s_gt) keep[res_tag.j] <= 1'b0;
        else           keep[res_tag.i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nms_pair_scheduler.sv
// Directed bench for nms_pair_scheduler with a behavioural CALU (rectangle overlap, any overlap passes IoU).
// Latency: CALU model returns results CALU_LAT cycles after calu_box1/2 change.
// Backpressure: out_ready optionally toggles every cycle during EMIT.
`timescale 1ns/1ps
module tb_nms_pair_scheduler;
  import nms_pkg::*;

  localparam int LAT = 12;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [6:0]  num_boxes;
  logic [63:0] in_data, calu_box1, calu_box2, out_data;
  logic        calu_overlap, calu_iou_pass, calu_s_gt;
  logic [15:0] pair_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] fr [8];
  logic [63:0] ex [8];

  nms_pair_scheduler #(.MAX_BOXES(64), .CALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_boxes(num_boxes),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .calu_box1(calu_box1), .calu_box2(calu_box2),
    .calu_overlap(calu_overlap), .calu_iou_pass(calu_iou_pass), .calu_s_gt(calu_s_gt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int x, input int y, input int w, input int h, input logic [15:0] s);
    logic [63:0] b;
    b = '0;
    b[X_MSB:X_LSB] = 12'(x);
    b[Y_MSB:Y_LSB] = 12'(y);
    b[W_MSB:W_LSB] = 12'(w);
    b[H_MSB:H_LSB] = 12'(h);
    b[S_MSB:S_LSB] = s;
    return b;
  endfunction

  function automatic logic [2:0] calu_eval(input logic [63:0] a, input logic [63:0] b);
    int ax, ay, aw, ah, bx, by, bw, bh;
    logic ov;
    ax = int'(a[X_MSB:X_LSB]); ay = int'(a[Y_MSB:Y_LSB]);
    aw = int'(a[W_MSB:W_LSB]); ah = int'(a[H_MSB:H_LSB]);
    bx = int'(b[X_MSB:X_LSB]); by = int'(b[Y_MSB:Y_LSB]);
    bw = int'(b[W_MSB:W_LSB]); bh = int'(b[H_MSB:H_LSB]);
    ov = (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    return {ov, ov, (a[S_MSB:S_LSB] > b[S_MSB:S_LSB])};
  endfunction

  logic [2:0] calu_q [LAT];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) calu_q[k] <= '0;
    end else begin
      calu_q[0] <= calu_eval(calu_box1, calu_box2);
      for (int k = 1; k < LAT; k++) calu_q[k] <= calu_q[k-1];
    end
  end
  assign {calu_overlap, calu_iou_pass, calu_s_gt} = calu_q[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_load(input string name, input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_boxes = 7'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < n; b++) begin
      in_valid = 1'b1;
      in_data  = fr[b];
      @(negedge clk);
      check({name, "_in_ready"}, in_ready, 1);
      if (b == 0) check({name, "_busy"}, busy, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input string name, input int n, input int exp_n, input int exp_pairs, input bit toggle);
    int got, done_cyc;
    bit seen_done, stalled;
    logic [63:0] held;
    got = 0; done_cyc = -1; seen_done = 1'b0; stalled = 1'b0; held = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 3000 && !seen_done; c++) begin
      @(negedge clk);
      if (stalled) begin
        check({name, "_hold_vld"}, out_valid, 1);
        check({name, "_hold_dat"}, out_data, held);
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) begin
        if (got < exp_n) begin
          check({name, "_out_data"}, out_data, ex[got]);
          check({name, "_out_last"}, out_last, (got == exp_n - 1));
        end else begin
          check({name, "_extra_out"}, 64'(got + 1), 64'(exp_n));
        end
        got++;
      end
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = c;
        check({name, "_pairs"}, pair_count, 64'(exp_pairs));
      end
      @(posedge clk); #1;
      out_ready = toggle ? ~out_ready : 1'b1;
    end
    check({name, "_done_seen"}, seen_done, 1);
    check({name, "_out_count"}, 64'(got), 64'(exp_n));
    if (n == 0) check({name, "_done_lat"}, 64'(done_cyc), 0);
    @(negedge clk);
    check({name, "_done_once"}, done, 0);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  task automatic run_frame(input string name, input int n, input int exp_n, input int exp_pairs, input bit toggle);
    start_load(name, n);
    collect(name, n, exp_n, exp_pairs, toggle);
  endtask

  initial begin
    int cyc, dn;
    rst_n = 1'b0; start = 1'b0; num_boxes = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pairs", pair_count, 0);
    check("rst_box1", calu_box1, 0);
    check("rst_box2", calu_box2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three disjoint boxes, stalled output stream
    fr[0] = mk(0, 0, 10, 10, 16'h3C00);
    fr[1] = mk(100, 100, 10, 10, 16'h3C00);
    fr[2] = mk(200, 200, 10, 10, 16'h3C00);
    ex[0] = fr[0]; ex[1] = fr[1]; ex[2] = fr[2];
    run_frame("disj", 3, 3, 3, 1'b1);

    // Identical boxes, higher score first survives
    fr[0] = mk(0, 0, 20, 20, 16'h3B33);
    fr[1] = mk(0, 0, 20, 20, 16'h3800);
    ex[0] = fr[0];
    run_frame("ident", 2, 1, 1, 1'b0);

    // Chain A>B>C: B removed by A, its row is skipped, C survives
    fr[0] = mk(0, 0, 20, 20, 16'h3B33);
    fr[1] = mk(10, 0, 20, 20, 16'h399A);
    fr[2] = mk(25, 0, 20, 20, 16'h3800);
    ex[0] = fr[0]; ex[1] = fr[2];
    run_frame("chain", 3, 2, 2, 1'b0);

    // X loses to Y, then X-vs-Z result must be discarded so Z survives
    fr[0] = mk(0, 0, 20, 20, 16'h3800);
    fr[1] = mk(10, 0, 20, 10, 16'h3B33);
    fr[2] = mk(0, 15, 5, 10, 16'h34CD);
    ex[0] = fr[1]; ex[1] = fr[2];
    run_frame("discard", 3, 2, 3, 1'b0);

    // Degenerate frame sizes
    run_frame("n0", 0, 0, 0, 1'b0);
    fr[0] = mk(7, 8, 9, 10, 16'h3555);
    ex[0] = fr[0];
    run_frame("n1", 1, 1, 0, 1'b1);

    // Reset in the middle of issuing pairs
    for (int b = 0; b < 5; b++) fr[b] = mk(100 * b, 0, 10, 10, 16'h3C00);
    start_load("midrst", 5);
    cyc = 0;
    while (pair_count < 16'd2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midrst_reach_issue", (pair_count >= 16'd2), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_box1", calu_box1, 0);
    check("midrst_box2", calu_box2, 0);
    check("midrst_pairs", pair_count, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("midrst_quiet", 64'(dn), 0);

    // Box0 suppresses box2; box2 is a later column of row 1
    fr[0] = mk(0, 0, 20, 20, 16'h3B33);
    fr[1] = mk(100, 0, 10, 10, 16'h3800);
    fr[2] = mk(5, 5, 10, 10, 16'h3800);
    fr[3] = mk(200, 0, 10, 10, 16'h3800);
    fr[4] = mk(300, 0, 10, 10, 16'h3800);
    ex[0] = fr[0]; ex[1] = fr[1]; ex[2] = fr[3]; ex[3] = fr[4];
`ifdef NMS_SKIP_SUPPRESSED_EN
    run_frame("skip", 5, 4, 7, 1'b1);
`else
    run_frame("skip", 5, 4, 8, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
